fetch_prefetch_queue: RTL and testbench

Parametrised instruction-fetch front end with a prefetch queue between instruction memory and decode. It generates sequential PCs and issues in-order requests to a request/response instruction memory port. Returned words are buffered with their PC and exception flag, and delivered to decode over a valid/ready handshake. Redirects (exception handler entry, ERET, branch/jump) flush queued and in-flight fetches.

---
 rtl/fetch_prefetch_queue.sv | 225 ++++++++++++++++++++++
 tb/tb_fetch_prefetch_queue.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_prefetch_queue.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : fetch_prefetch_queue                                          |
// | Purpose  : Sequential PC generator issuing in-order instruction-memory   |
// |            requests, with a prefetch queue feeding decode over           |
// |            valid/ready. Redirects flush queued and in-flight fetches.    |
// | Options  : FETCH_PERF_CNT_EN adds perf_fetched/perf_flushed/perf_stall.  |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module fetch_prefetch_queue #(
  parameter int unsigned DEPTH      = 4,
  parameter logic [31:0] RESET_PC   = 32'h0000_3000,
  parameter logic [31:0] HANDLER_PC = 32'h0000_4180,
  parameter logic [31:0] TEXT_LO    = 32'h0000_3000,
  parameter logic [31:0] TEXT_HI    = 32'h0000_4FFC
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        goto_handler,
  input  logic        eret,
  input  logic [31:0] epc,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic [31:0] if_pcp4,
  output logic        if_exc
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_flushed,
  output logic [31:0] perf_stall
`endif
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;
  localparam logic [PW:0] DEPTH_V = DEPTH[PW:0];

  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic          handler_q, handler_d;     // fetch_pc is a fresh handler entry
  logic          exc_stall_q, exc_stall_d; // exception entry pushed, wait for redirect
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] outstanding_q, outstanding_d;
  logic [PW-1:0] drop_q, drop_d;
  logic [AW-1:0] tag_wr_q, tag_wr_d, tag_rd_q, tag_rd_d;
  logic [31:0]   ent_pc_q [DEPTH];
  logic [31:0]   ent_pc_d [DEPTH];
  logic [31:0]   ent_instr_q [DEPTH];
  logic [31:0]   ent_instr_d [DEPTH];
  logic          ent_exc_q [DEPTH];
  logic          ent_exc_d [DEPTH];
  logic [31:0]   tag_pc_q [DEPTH];
  logic [31:0]   tag_pc_d [DEPTH];

  logic          redirect;
  logic [31:0]   redirect_target;
  logic [PW-1:0] occupancy;
  logic          empty;
  logic          pc_legal;
  logic          slot_free;
  logic          grant;
  logic          rsp_drop;
  logic          rsp_push;
  logic          exc_push;
  logic          pop;
  logic [AW-1:0] head_idx;
  logic [AW-1:0] tail_idx;

  // Head-of-queue views and request/issue decisions.
  always_comb begin
    redirect        = goto_handler | eret | redirect_valid;
    redirect_target = goto_handler ? HANDLER_PC : (eret ? epc : redirect_pc);
    occupancy       = wr_ptr_q - rd_ptr_q;
    empty           = (wr_ptr_q == rd_ptr_q);
    head_idx        = rd_ptr_q[AW-1:0];
    tail_idx        = wr_ptr_q[AW-1:0];
    pc_legal        = ((fetch_pc_q[1:0] == 2'b00) && (fetch_pc_q >= TEXT_LO) &&
                       (fetch_pc_q <= TEXT_HI)) ||
                      (handler_q && (fetch_pc_q == HANDLER_PC));
    slot_free       = ({1'b0, occupancy} + {1'b0, outstanding_q}) < DEPTH_V;

    imem_req  = ~reset & ~redirect & slot_free & pc_legal & ~exc_stall_q;
    imem_addr = fetch_pc_q;
    grant     = imem_req & imem_gnt;

    rsp_drop  = imem_rvalid & (drop_q != '0);
    rsp_push  = imem_rvalid & (drop_q == '0) & ~redirect;
    // An illegal PC becomes a queue entry only once nothing is still in flight.
    exc_push  = ~reset & ~redirect & ~pc_legal & ~exc_stall_q & ~imem_rvalid &
                (outstanding_q == '0) & slot_free;

    if_valid  = ~empty;
    if_pc     = ent_pc_q[head_idx];
    if_pcp4   = ent_pc_q[head_idx] + 32'd4;
    if_exc    = ent_exc_q[head_idx];
    if_instr  = ent_exc_q[head_idx] ? 32'd0 : ent_instr_q[head_idx];
    pop       = if_valid & if_ready;
  end

  // Next-state for PC, counters, tag FIFO and queue storage.
  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    handler_d     = handler_q;
    exc_stall_d   = exc_stall_q;
    outstanding_d = outstanding_q + PW'(grant) - PW'(imem_rvalid);
    drop_d        = rsp_drop ? (drop_q - PW'(1)) : drop_q;
    tag_wr_d      = tag_wr_q;
    tag_rd_d      = tag_rd_q;
    tag_pc_d      = tag_pc_q;
    ent_pc_d      = ent_pc_q;
    ent_instr_d   = ent_instr_q;
    ent_exc_d     = ent_exc_q;
    rd_ptr_d      = rd_ptr_q + PW'(pop);
    wr_ptr_d      = wr_ptr_q;

    if (grant) begin
      tag_pc_d[tag_wr_q] = fetch_pc_q;
      tag_wr_d           = tag_wr_q + AW'(1);
      fetch_pc_d         = fetch_pc_q + 32'd4;
      handler_d          = 1'b0;
    end
    if (imem_rvalid) begin
      tag_rd_d = tag_rd_q + AW'(1);
    end

    if (rsp_push) begin
      ent_pc_d[tail_idx]    = tag_pc_q[tag_rd_q];
      ent_instr_d[tail_idx] = imem_rdata;
      ent_exc_d[tail_idx]   = 1'b0;
      wr_ptr_d              = wr_ptr_q + PW'(1);
    end else if (exc_push) begin
      ent_pc_d[tail_idx]    = fetch_pc_q;
      ent_instr_d[tail_idx] = 32'd0;
      ent_exc_d[tail_idx]   = 1'b1;
      wr_ptr_d              = wr_ptr_q + PW'(1);
      exc_stall_d           = 1'b1;
    end

    // The same-cycle dequeue completes first, then everything left is flushed.
    if (redirect) begin
      fetch_pc_d  = redirect_target;
      handler_d   = goto_handler;
      exc_stall_d = 1'b0;
      wr_ptr_d    = rd_ptr_d;
      drop_d      = outstanding_d;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc_q    <= RESET_PC;
      handler_q     <= 1'b0;
      exc_stall_q   <= 1'b0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      outstanding_q <= '0;
      drop_q        <= '0;
      tag_wr_q      <= '0;
      tag_rd_q      <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        ent_pc_q[i]    <= RESET_PC;
        ent_instr_q[i] <= 32'd0;
        ent_exc_q[i]   <= 1'b0;
        tag_pc_q[i]    <= 32'd0;
      end
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      handler_q     <= handler_d;
      exc_stall_q   <= exc_stall_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      outstanding_q <= outstanding_d;
      drop_q        <= drop_d;
      tag_wr_q      <= tag_wr_d;
      tag_rd_q      <= tag_rd_d;
      ent_pc_q      <= ent_pc_d;
      ent_instr_q   <= ent_instr_d;
      ent_exc_q     <= ent_exc_d;
      tag_pc_q      <= tag_pc_d;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [31:0]   perf_fetched_q, perf_fetched_d;
  logic [31:0]   perf_flushed_q, perf_flushed_d;
  logic [31:0]   perf_stall_q, perf_stall_d;
  logic [PW-1:0] flush_entries;

  // Event counters: pushed responses, flushed work, decode starvation cycles.
  always_comb begin
    flush_entries  = redirect ? (wr_ptr_q - rd_ptr_d) : '0;
    perf_fetched_d = perf_fetched_q + 32'(rsp_push);
    perf_flushed_d = perf_flushed_q + 32'(flush_entries) +
                     32'(imem_rvalid & ((drop_q != '0) | redirect));
    perf_stall_d   = perf_stall_q + 32'(if_ready & ~if_valid);
    perf_fetched   = perf_fetched_q;
    perf_flushed   = perf_flushed_q;
    perf_stall     = perf_stall_q;
  end

  // Counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_fetched_q <= 32'd0;
      perf_flushed_q <= 32'd0;
      perf_stall_q   <= 32'd0;
    end else begin
      perf_fetched_q <= perf_fetched_d;
      perf_flushed_q <= perf_flushed_d;
      perf_stall_q   <= perf_stall_d;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_fetch_prefetch_queue.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_fetch_prefetch_queue                                       |
// | Purpose  : Self-checking bench for fetch_prefetch_queue: directed        |
// |            scenarios plus randomized traffic against a program-order     |
// |            reference model.                                              |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_fetch_prefetch_queue;

  localparam logic [31:0] RST_PC = 32'h0000_3000;
  localparam logic [31:0] HND_PC = 32'h0000_4180;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        goto_handler = 1'b0, eret = 1'b0, redirect_valid = 1'b0;
  logic [31:0] epc = 32'd0, redirect_pc = 32'd0;
  logic        imem_req, imem_gnt = 1'b0, imem_rvalid = 1'b0;
  logic [31:0] imem_addr, imem_rdata = 32'd0;
  logic        if_valid, if_ready = 1'b0, if_exc;
  logic [31:0] if_instr, if_pc, if_pcp4;

  fetch_prefetch_queue dut (
    .clk(clk), .reset(reset), .goto_handler(goto_handler), .eret(eret), .epc(epc),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .if_valid(if_valid), .if_ready(if_ready), .if_instr(if_instr),
    .if_pc(if_pc), .if_pcp4(if_pcp4), .if_exc(if_exc)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Memory and reference-model state.
  logic [31:0] pend[$];
  int          gnt_pct = 100, rsp_pct = 100;
  logic [31:0] m_req_pc = RST_PC, m_exp_pc = RST_PC;
  logic        m_blocked = 1'b0;
  int          grants = 0, deqs = 0;
  logic [31:0] last_grant_addr = 32'd0;
  logic        deq_flag = 1'b0, last_deq_exc = 1'b0, saw_req_5000 = 1'b0;
  logic [31:0] last_deq_pc = 32'd0, last_deq_instr = 32'd0;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h5A5A_0F0F;
  endfunction

  function automatic logic legal(input logic [31:0] a);
    return (a[1:0] == 2'b00) && (a >= 32'h0000_3000) && (a <= 32'h0000_4FFC);
  endfunction

  // One clock cycle: drive memory, score handshakes, advance model.
  task automatic step();
    logic        do_gnt, redir;
    logic [31:0] tgt;
    imem_gnt    = (gnt_pct != 0) && ($urandom_range(0, 99) < gnt_pct);
    imem_rvalid = 1'b0;
    imem_rdata  = 32'd0;
    if (pend.size() > 0 && !reset && ($urandom_range(0, 99) < rsp_pct)) begin
      imem_rvalid = 1'b1;
      imem_rdata  = memf(pend[0]);
    end
    #1;
    redir    = goto_handler | eret | redirect_valid;
    tgt      = goto_handler ? HND_PC : (eret ? epc : redirect_pc);
    deq_flag = 1'b0;
    do_gnt   = 1'b0;
    if (!reset) begin
      if (redir) begin
        checks++;
        if (imem_req !== 1'b0) begin failures++; $display("FAIL req_in_redirect: got %b want 0", imem_req); end
      end
      if (imem_req === 1'b1) begin
        if (imem_addr == 32'h0000_5000) saw_req_5000 = 1'b1;
        checks++;
        if (imem_addr !== m_req_pc) begin failures++; $display("FAIL req_addr: got %h want %h", imem_addr, m_req_pc); end
        checks++;
        if (!legal(imem_addr)) begin failures++; $display("FAIL req_legal: got addr %h want a legal address", imem_addr); end
      end
      if (if_valid === 1'b1 && if_ready) begin
        deq_flag = 1'b1; deqs++;
        last_deq_pc = if_pc; last_deq_exc = if_exc; last_deq_instr = if_instr;
        checks++;
        if (m_blocked) begin failures++; $display("FAIL deq_after_exc: got pc %h want no delivery", if_pc); end
        checks++;
        if (if_pc !== m_exp_pc) begin failures++; $display("FAIL deq_pc: got %h want %h", if_pc, m_exp_pc); end
        checks++;
        if (if_pcp4 !== m_exp_pc + 32'd4) begin failures++; $display("FAIL deq_pcp4: got %h want %h", if_pcp4, m_exp_pc + 32'd4); end
        if (legal(m_exp_pc)) begin
          checks++;
          if (if_exc !== 1'b0 || if_instr !== memf(m_exp_pc)) begin
            failures++; $display("FAIL deq_data: got exc=%b instr=%h want exc=0 instr=%h", if_exc, if_instr, memf(m_exp_pc));
          end
        end else begin
          checks++;
          if (if_exc !== 1'b1 || if_instr !== 32'd0) begin
            failures++; $display("FAIL deq_exc: got exc=%b instr=%h want exc=1 instr=0", if_exc, if_instr);
          end
          m_blocked = 1'b1;
        end
        m_exp_pc = m_exp_pc + 32'd4;
      end
      do_gnt = (imem_req === 1'b1) && imem_gnt;
      if (do_gnt) begin
        grants++; last_grant_addr = imem_addr; m_req_pc = m_req_pc + 32'd4;
      end
      if (redir) begin
        m_req_pc = tgt; m_exp_pc = tgt; m_blocked = 1'b0;
      end
    end
    @(posedge clk);
    if (reset) begin
      pend.delete();
      m_req_pc = RST_PC; m_exp_pc = RST_PC; m_blocked = 1'b0;
    end else begin
      if (imem_rvalid && pend.size() > 0) void'(pend.pop_front());
      if (do_gnt) pend.push_back(last_grant_addr);
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    goto_handler = 0; eret = 0; redirect_valid = 0; if_ready = 0;
    gnt_pct = 100; rsp_pct = 100;
    reset = 1'b1;
    repeat (2) step();
    reset = 1'b0;
  endtask

  task automatic redirect_once(input logic g, input logic e, input logic r,
                               input logic [31:0] ep, input logic [31:0] rp);
    goto_handler = g; eret = e; redirect_valid = r; epc = ep; redirect_pc = rp;
    step();
    goto_handler = 0; eret = 0; redirect_valid = 0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) step();
    #1;
    checks++;
    if (imem_req !== 1'b0) begin failures++; $display("FAIL reset_req: got %b want 0", imem_req); end
    checks++;
    if (if_valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b want 0", if_valid); end
    checks++;
    if (if_pc !== RST_PC || if_pcp4 !== RST_PC + 32'd4) begin
      failures++; $display("FAIL reset_pc: got %h/%h want %h/%h", if_pc, if_pcp4, RST_PC, RST_PC + 32'd4);
    end
    checks++;
    if (if_instr !== 32'd0 || if_exc !== 1'b0) begin
      failures++; $display("FAIL reset_instr: got instr=%h exc=%b want 0/0", if_instr, if_exc);
    end
    reset = 1'b0;
  endtask

  task automatic test_sequential();
    int first;
    int n;
    do_reset();
    if_ready = 1'b1;
    first = 0;
    for (int i = 1; i <= 10 && first == 0; i++) begin
      step();
      if (deq_flag) first = i;
    end
    checks++;
    if (first != 3) begin failures++; $display("FAIL first_valid_latency: got %0d want 3", first); end
    checks++;
    if (last_deq_pc !== RST_PC) begin failures++; $display("FAIL first_pc: got %h want %h", last_deq_pc, RST_PC); end
    n = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (deq_flag) n++;
    end
    checks++;
    if (n != 8) begin failures++; $display("FAIL one_per_cycle: got %0d want 8", n); end
  endtask

  task automatic test_backpressure();
    int n;
    do_reset();
    grants = 0;
    repeat (12) step();
    checks++;
    if (grants != 4) begin failures++; $display("FAIL full_grants: got %0d want 4", grants); end
    checks++;
    if (imem_req !== 1'b0 || if_valid !== 1'b1) begin
      failures++; $display("FAIL full_state: got req=%b valid=%b want 0/1", imem_req, if_valid);
    end
    if_ready = 1'b1;
    n = 0;
    repeat (4) begin step(); if (deq_flag) n++; end
    checks++;
    if (n != 4) begin failures++; $display("FAIL drain_count: got %0d want 4", n); end
    grants = 0;
    repeat (6) step();
    checks++;
    if (grants == 0) begin failures++; $display("FAIL resume_fetch: got %0d grants want >0", grants); end
  endtask

  task automatic test_redirect_flush();
    logic got;
    do_reset();
    rsp_pct = 0; grants = 0;
    repeat (2) step();
    gnt_pct = 0;
    checks++;
    if (grants != 2) begin failures++; $display("FAIL flush_setup_grants: got %0d want 2", grants); end
    redirect_once(1'b0, 1'b0, 1'b1, 32'd0, 32'h0000_3100);
    gnt_pct = 100; rsp_pct = 100; if_ready = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 30 && !got; i++) begin step(); got = deq_flag; end
    checks++;
    if (!got || last_deq_pc !== 32'h0000_3100 || last_deq_instr !== memf(32'h0000_3100)) begin
      failures++; $display("FAIL flush_first: got pc=%h instr=%h want pc=00003100 instr=%h", last_deq_pc, last_deq_instr, memf(32'h0000_3100));
    end
  endtask

  task automatic test_priority();
    int g0;
    do_reset();
    redirect_once(1'b1, 1'b1, 1'b1, 32'h0000_3200, 32'h0000_3300);
    g0 = grants;
    for (int i = 0; i < 10 && grants == g0; i++) step();
    checks++;
    if (grants == g0 || last_grant_addr !== HND_PC) begin
      failures++; $display("FAIL priority_target: got %h want %h", last_grant_addr, HND_PC);
    end
  endtask

  task automatic test_text_end();
    logic got;
    do_reset();
    if_ready = 1'b1;
    redirect_once(1'b0, 1'b0, 1'b1, 32'd0, 32'h0000_4FF0);
    saw_req_5000 = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      step();
      got = deq_flag && (last_deq_pc == 32'h0000_5000);
    end
    checks++;
    if (!got || last_deq_exc !== 1'b1 || last_deq_instr !== 32'd0) begin
      failures++; $display("FAIL text_end_exc: got found=%b exc=%b instr=%h want 1/1/0", got, last_deq_exc, last_deq_instr);
    end
    checks++;
    if (saw_req_5000) begin failures++; $display("FAIL text_end_req: got request to 00005000 want none"); end
    redirect_once(1'b0, 1'b1, 1'b0, 32'h0000_3000, 32'd0);
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin step(); got = deq_flag; end
    checks++;
    if (!got || last_deq_pc !== 32'h0000_3000 || last_deq_exc !== 1'b0) begin
      failures++; $display("FAIL eret_resume: got pc=%h exc=%b want 00003000/0", last_deq_pc, last_deq_exc);
    end
  endtask

  task automatic test_misaligned();
    logic got;
    do_reset();
    if_ready = 1'b1;
    redirect_once(1'b0, 1'b0, 1'b1, 32'd0, 32'h0000_3002);
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin step(); got = deq_flag; end
    checks++;
    if (!got || last_deq_pc !== 32'h0000_3002 || last_deq_exc !== 1'b1 || last_deq_instr !== 32'd0) begin
      failures++; $display("FAIL misaligned_exc: got pc=%h exc=%b instr=%h want 00003002/1/0", last_deq_pc, last_deq_exc, last_deq_instr);
    end
    redirect_once(1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin step(); got = deq_flag; end
    checks++;
    if (!got || last_deq_pc !== HND_PC || last_deq_exc !== 1'b0) begin
      failures++; $display("FAIL handler_entry: got pc=%h exc=%b want %h/0", last_deq_pc, last_deq_exc, HND_PC);
    end
  endtask

  task automatic test_random();
    logic [31:0] t;
    int          d0;
    do_reset();
    d0 = deqs;
    for (int i = 0; i < 1500; i++) begin
      if (i % 100 == 0) begin
        gnt_pct = $urandom_range(30, 100);
        rsp_pct = $urandom_range(20, 100);
      end
      if_ready = ($urandom_range(0, 99) < 60);
      if ($urandom_range(0, 99) < 3) begin
        case ($urandom_range(0, 4))
          0: t = 32'h0000_3000 + {$urandom_range(0, 32'h7FF), 2'b00};
          1: t = 32'h0000_4FF4;
          2: t = 32'h0000_3002;
          3: t = 32'h0000_2FFC;
          default: t = 32'h0000_3800 + {$urandom_range(0, 32'h3F), 2'b00};
        endcase
        case ($urandom_range(0, 9))
          0: begin goto_handler = 1; eret = $urandom_range(0, 1); redirect_valid = $urandom_range(0, 1); end
          1, 2: begin eret = 1; redirect_valid = $urandom_range(0, 1); end
          default: redirect_valid = 1;
        endcase
        epc = t; redirect_pc = t ^ 32'h0000_0100;
      end
      step();
      goto_handler = 0; eret = 0; redirect_valid = 0;
    end
    checks++;
    if (deqs == d0) begin failures++; $display("FAIL random_progress: got 0 deliveries want >0"); end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_backpressure();
    test_redirect_flush();
    test_priority();
    test_text_end();
    test_misaligned();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
